mantissa_sub_normalize: RTL and testbench

Effective-subtraction mantissa path for the pipelined floating point unit. It is the counterpart of the mantissa adder used on the addition path. It takes two aligned 24-bit mantissas (hidden bit included), subtracts them, and fixes the result sign on operand swap. It then renormalizes by leading-zero count and adjusts the exponent. It sits after the alignment stage and feeds the pack/round stage.

---
 rtl/mantissa_sub_normalize.sv | 146 ++++++++++++++
 tb/tb_mantissa_sub_normalize.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mantissa_sub_normalize.sv
// Three-stage effective-subtraction mantissa path: subtract with sign fix-up,
// leading-zero count, then renormalize with exponent adjust / underflow flush.
module mantissa_sub_normalize #(
  parameter int MW  = 24,
  parameter int EW  = 8,
  parameter int LZW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [MW-1:0] i1,
  input  logic [MW-1:0] i2,
  input  logic [EW-1:0] exp_in,
  input  logic          sign_in,
  output logic          out_valid,
  output logic [MW-1:0] diff,
  output logic [EW-1:0] exp_out,
  output logic          sign_out,
  output logic          zero,
  output logic          underflow
);

  logic [MW:0]    subFull;
  logic           s1Valid_q, s1Neg_q, s1Sign_q;
  logic [MW-1:0]  s1Diff_q;
  logic [EW-1:0]  s1Exp_q;

  logic [MW-1:0]  mag_d;
  logic [LZW-1:0] lz_d;
  logic           lzFound;
  logic           s2Valid_q, s2Sign_q;
  logic [MW-1:0]  s2Mag_q;
  logic [LZW-1:0] s2Lz_q;
  logic [EW-1:0]  s2Exp_q;

  logic [EW:0]    expWide, lzWide, expDiff;
  logic [MW-1:0]  diff_d;
  logic [EW-1:0]  expOut_d;
  logic           signOut_d, zero_d, underflow_d;
  logic           outValid_q, signOut_q, zero_q, underflow_q;
  logic [MW-1:0]  diff_q;
  logic [EW-1:0]  expOut_q;

  // Top bit of the MW+1-bit result is the carry-out; no carry means i1 < i2.
  assign subFull = {1'b0, i1} + {1'b0, ~i2} + (MW+1)'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1Valid_q <= 1'b0;
      s1Diff_q  <= '0;
      s1Neg_q   <= 1'b0;
      s1Exp_q   <= '0;
      s1Sign_q  <= 1'b0;
    end else begin
      s1Valid_q <= in_valid;
      if (in_valid) begin
        s1Diff_q <= subFull[MW-1:0];
        s1Neg_q  <= ~subFull[MW];
        s1Exp_q  <= exp_in;
        s1Sign_q <= sign_in;
      end
    end
  end

  assign mag_d = s1Neg_q ? (~s1Diff_q + MW'(1)) : s1Diff_q;

  always_comb begin
    lz_d    = LZW'(MW);
    lzFound = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!lzFound && mag_d[i]) begin
        lz_d    = LZW'(MW - 1 - i);
        lzFound = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2Valid_q <= 1'b0;
      s2Mag_q   <= '0;
      s2Lz_q    <= '0;
      s2Sign_q  <= 1'b0;
      s2Exp_q   <= '0;
    end else begin
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        s2Mag_q  <= mag_d;
        s2Lz_q   <= lz_d;
        s2Sign_q <= s1Sign_q ^ s1Neg_q;
        s2Exp_q  <= s1Exp_q;
      end
    end
  end

  // exp - lz at EW+1 bits: a set top bit or a zero result both mean lz >= exp.
  assign expWide = {1'b0, s2Exp_q};
  assign lzWide  = {{(EW + 1 - LZW){1'b0}}, s2Lz_q};
  assign expDiff = expWide - lzWide;

  always_comb begin
    diff_d      = '0;
    expOut_d    = '0;
    signOut_d   = 1'b0;
    zero_d      = 1'b0;
    underflow_d = 1'b0;
    if (s2Mag_q == '0) begin
      zero_d = 1'b1;
    end else if (expDiff[EW] || (expDiff == '0)) begin
      signOut_d   = s2Sign_q;
      underflow_d = 1'b1;
    end else begin
      diff_d    = s2Mag_q << s2Lz_q;
      expOut_d  = expDiff[EW-1:0];
      signOut_d = s2Sign_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outValid_q  <= 1'b0;
      diff_q      <= '0;
      expOut_q    <= '0;
      signOut_q   <= 1'b0;
      zero_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      outValid_q <= s2Valid_q;
      if (s2Valid_q) begin
        diff_q      <= diff_d;
        expOut_q    <= expOut_d;
        signOut_q   <= signOut_d;
        zero_q      <= zero_d;
        underflow_q <= underflow_d;
      end
    end
  end

  assign out_valid = outValid_q;
  assign diff      = diff_q;
  assign exp_out   = expOut_q;
  assign sign_out  = signOut_q;
  assign zero      = zero_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_mantissa_sub_normalize.sv
// Bench for mantissa_sub_normalize: arithmetic reference model with a
// due-cycle scoreboard checked every cycle, plus hand-computed literal checks.
module tb_mantissa_sub_normalize;
  localparam int MW  = 24;
  localparam int EW  = 8;
  localparam int LZW = 5;

  logic          clk = 1'b0;
  logic          reset, in_valid, sign_in;
  logic [MW-1:0] i1, i2;
  logic [EW-1:0] exp_in;
  logic          out_valid, sign_out, zero, underflow;
  logic [MW-1:0] diff;
  logic [EW-1:0] exp_out;

  typedef struct packed {
    logic [MW-1:0] diff;
    logic [EW-1:0] e;
    logic          s;
    logic          z;
    logic          u;
  } res_t;

  typedef struct {
    int   due;
    res_t r;
  } pend_t;

  pend_t pendQ[$];
  res_t  held;
  int    cycle   = 0;
  bit    started = 1'b0;
  int    checks  = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  mantissa_sub_normalize #(.MW(MW), .EW(EW), .LZW(LZW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .i1(i1), .i2(i2), .exp_in(exp_in), .sign_in(sign_in),
    .out_valid(out_valid), .diff(diff), .exp_out(exp_out),
    .sign_out(sign_out), .zero(zero), .underflow(underflow)
  );

  function automatic res_t mk(input logic [MW-1:0] d, input logic [EW-1:0] e,
                              input logic s, input logic z, input logic u);
    res_t r;
    r.diff = d; r.e = e; r.s = s; r.z = z; r.u = u;
    return r;
  endfunction

  // Plain arithmetic: |a-b|, shift left until the top bit is set, count shifts.
  function automatic res_t model(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                 input logic [EW-1:0] e, input logic s);
    res_t        r;
    int unsigned m;
    int          lz;
    logic        neg;
    r   = '0;
    neg = (a < b);
    m   = neg ? ({8'h0, b} - {8'h0, a}) : ({8'h0, a} - {8'h0, b});
    if (m == 0) begin
      r.z = 1'b1;
    end else begin
      lz = 0;
      while (m < 32'h0080_0000) begin
        m  = m << 1;
        lz++;
      end
      r.s = s ^ neg;
      if (lz >= int'(e)) begin
        r.u = 1'b1;
      end else begin
        r.diff = m[MW-1:0];
        r.e    = e - EW'(lz);
      end
    end
    return r;
  endfunction

  task automatic applyStimulus(input logic v, input logic [MW-1:0] a, input logic [MW-1:0] b,
                               input logic [EW-1:0] e, input logic s);
    in_valid = v; i1 = a; i2 = b; exp_in = e; sign_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 24'h5A5A5A, 24'h123456, 8'h33, 1'b1);
  endtask

  task automatic checkOutput(input string name, input logic expV, input res_t want);
    checks++;
    if (out_valid !== expV || {diff, exp_out, sign_out, zero, underflow} !== want) begin
      failures++;
      $display("[TB] FAIL %s: got v=%b diff=%h exp=%h s=%b z=%b u=%b, want v=%b diff=%h exp=%h s=%b z=%b u=%b",
               name, out_valid, diff, exp_out, sign_out, zero, underflow,
               expV, want.diff, want.e, want.s, want.z, want.u);
    end
  endtask

  task automatic checkModel(input string name, input res_t got, input res_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: model diff=%h exp=%h s=%b z=%b u=%b, want diff=%h exp=%h s=%b z=%b u=%b",
               name, got.diff, got.e, got.s, got.z, got.u, want.diff, want.e, want.s, want.z, want.u);
    end
  endtask

  // Scoreboard feed: each accepted operand is due at the output 3 edges later.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      pendQ.delete();
      held    = '0;
      started = 1'b1;
    end else if (in_valid) begin
      pendQ.push_back('{due: cycle + 3, r: model(i1, i2, exp_in, sign_in)});
    end
    cycle++;
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      logic expV;
      expV = 1'b0;
      if (pendQ.size() > 0 && pendQ[0].due == cycle) begin
        held = pendQ[0].r;
        void'(pendQ.pop_front());
        expV = 1'b1;
      end
      checks++;
      if (out_valid !== expV || {diff, exp_out, sign_out, zero, underflow} !== held) begin
        failures++;
        $display("[TB] FAIL scoreboard cycle %0d: got v=%b diff=%h exp=%h s=%b z=%b u=%b, want v=%b diff=%h exp=%h s=%b z=%b u=%b",
                 cycle, out_valid, diff, exp_out, sign_out, zero, underflow,
                 expV, held.diff, held.e, held.s, held.z, held.u);
      end
    end
  end

  logic [MW-1:0] tblA [7] = '{24'h800000, 24'h800000, 24'h000000, 24'hFFFFFF, 24'h000001, 24'h000000, 24'h123456};
  logic [MW-1:0] tblB [7] = '{24'h7F0000, 24'h7F0000, 24'h000000, 24'h000000, 24'h000000, 24'h000001, 24'h654321};
  logic [EW-1:0] tblE [7] = '{8'h07, 8'h08, 8'h01, 8'h01, 8'hFF, 8'h18, 8'h9C};
  logic          tblS [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    reset = 1'b1; in_valid = 1'b0; i1 = '0; i2 = '0; exp_in = '0; sign_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("reset_state", 1'b0, '0);

    checkModel("model_t1",    model(24'h800000, 24'h400000, 8'h80, 1'b0), mk(24'h800000, 8'h7F, 1'b0, 1'b0, 1'b0));
    checkModel("model_lz23",  model(24'h800000, 24'h7FFFFF, 8'h80, 1'b0), mk(24'h800000, 8'h69, 1'b0, 1'b0, 1'b0));
    checkModel("model_lzeq",  model(24'h800000, 24'h7F0000, 8'h07, 1'b0), mk(24'h000000, 8'h00, 1'b0, 1'b0, 1'b1));
    checkModel("model_lzlt",  model(24'h800000, 24'h7F0000, 8'h08, 1'b1), mk(24'h800000, 8'h01, 1'b1, 1'b0, 1'b0));

    applyStimulus(1'b1, 24'h800000, 24'h400000, 8'h80, 1'b0); idle(2);
    checkOutput("t1_basic", 1'b1, mk(24'h800000, 8'h7F, 1'b0, 1'b0, 1'b0));
    applyStimulus(1'b1, 24'h400000, 24'h800000, 8'h80, 1'b0); idle(2);
    checkOutput("t2_swap", 1'b1, mk(24'h800000, 8'h7F, 1'b1, 1'b0, 1'b0));
    applyStimulus(1'b1, 24'hC00000, 24'hC00000, 8'h90, 1'b1); idle(2);
    checkOutput("t3_cancel", 1'b1, mk(24'h000000, 8'h00, 1'b0, 1'b1, 1'b0));
    applyStimulus(1'b1, 24'h800000, 24'h7FFFFF, 8'h80, 1'b0); idle(2);
    checkOutput("t4_lz23", 1'b1, mk(24'h800000, 8'h69, 1'b0, 1'b0, 1'b0));
    applyStimulus(1'b1, 24'h800000, 24'h7FFFFF, 8'h10, 1'b0); idle(2);
    checkOutput("t4_underflow", 1'b1, mk(24'h000000, 8'h00, 1'b0, 1'b0, 1'b1));

    applyStimulus(1'b1, 24'h900000, 24'h100000, 8'h40, 1'b0);
    applyStimulus(1'b1, 24'h100000, 24'h900000, 8'h40, 1'b0);
    idle(1);
    checkOutput("t5_A", 1'b1, mk(24'h800000, 8'h40, 1'b0, 1'b0, 1'b0));
    applyStimulus(1'b1, 24'hFFFFFF, 24'hFFFFFF, 8'h40, 1'b0);
    checkOutput("t5_B", 1'b1, mk(24'h800000, 8'h40, 1'b1, 1'b0, 1'b0));
    idle(1);
    checkOutput("t5_bubble", 1'b0, mk(24'h800000, 8'h40, 1'b1, 1'b0, 1'b0));
    idle(1);
    checkOutput("t5_C", 1'b1, mk(24'h000000, 8'h00, 1'b0, 1'b1, 1'b0));
    idle(2);
    checkOutput("t5_hold", 1'b0, mk(24'h000000, 8'h00, 1'b0, 1'b1, 1'b0));

    applyStimulus(1'b1, 24'hA00000, 24'h200000, 8'h50, 1'b0);
    applyStimulus(1'b1, 24'h300000, 24'h100000, 8'h50, 1'b1);
    reset = 1'b1;
    applyStimulus(1'b1, 24'hF00000, 24'h0F0000, 8'h50, 1'b0);
    reset = 1'b0;
    checkOutput("t6_after_reset", 1'b0, '0);
    idle(3);
    checkOutput("t6_quiet", 1'b0, '0);
    applyStimulus(1'b1, 24'hF00000, 24'h100000, 8'h20, 1'b1); idle(2);
    checkOutput("t6_new_op", 1'b1, mk(24'hE00000, 8'h20, 1'b1, 1'b0, 1'b0));

    for (int k = 0; k < 7; k++) applyStimulus(1'b1, tblA[k], tblB[k], tblE[k], tblS[k]);
    idle(5);
    checks++;
    if (pendQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d results still pending, want 0", pendQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
